alu_wb_stage: RTL
=================

Name: alu_wb_stage

Overview:
Writeback/retire stage directly downstream of the 16-bit ALU. Consumes the ALU result, result-valid, masked flag vector and flag-control bits, plus the instruction's destination register. Produces a registered register-file write port and holds the architectural PSR {C,F,Z,L,N}; PSR.C feeds back to the ALU carry-in for the ADDC family. Implements the WAIT stall, a flush, and a retired-instruction counter.

Parameters:
WIDTH, 16, datapath width; must match the ALU.
RF_ADDR_W, 4, register-file address width (16 registers).

Ports:
clk  in  1  single clock; all state changes on rising edge
reset_n  in  1  synchronous, active-low reset, sampled on rising edge of clk
in_valid  in  1  upstream holds a completed ALU operation
in_ready  out  1  stage accepts this cycle; combinational from state only
in_y  in  WIDTH  ALU result
in_y_valid  in  1  1 = architectural writeback; 0 for CMP family and WAIT
in_flags  in  5  ALU flags_out {C,F,Z,L,N}, already masked and zeroed when disabled
in_flags_en  in  1  PSR update enable
in_flags_sel  in  5  per-bit PSR write mask {C,F,Z,L,N}
in_rdest  in  RF_ADDR_W  destination register index
in_is_wait  in  1  instruction is WAIT
wake  in  1  level; releases WAIT
flush  in  1  discard current acceptance and leave WAIT
rf_we  out  1  register-file write strobe, one cycle
rf_waddr  out  RF_ADDR_W  write address
rf_wdata  out  WIDTH  write data
psr  out  5  architectural PSR {C,F,Z,L,N}
psr_c  out  1  psr[4], to ALU psr_c_in
waiting  out  1  high while in WAIT state
retired_count  out  16  count of retired non-WAIT instructions

Behaviour:
- Reset (reset_n low at edge): state=RUN; rf_we=0, rf_waddr=0, rf_wdata=0, psr=0, waiting=0, retired_count=0. Reset overrides all other inputs, including mid-WAIT.
- Accept = in_valid & in_ready & ~flush. in_ready = (state==RUN).
- States: RUN, WAIT. RUN->WAIT on accept with in_is_wait=1. WAIT->RUN on wake=1 or flush=1. Otherwise hold.
- Latency: accepted operation appears on rf_* exactly one cycle after the accept edge (registered). rf_we = accept & in_y_valid & ~in_is_wait; deasserts the following cycle unless there is another accept. rf_waddr/rf_wdata load only when rf_we loads 1; otherwise they hold.
- PSR update on accept with in_flags_en=1 (WAIT included if enabled): psr <= (psr & ~in_flags_sel) | (in_flags & in_flags_sel). Unselected bits are never altered. When in_flags_en=0, PSR holds.
- psr_c is a register output. Back-to-back ADDC sees the carry from the previous accepted instruction with no bubble, because the ALU evaluates the next op in the cycle after the accept edge.
- retired_count increments by 1 on each accept with in_is_wait=0 (CMP included) and wraps 0xFFFF->0x0000.
- WAIT: waiting=1 from the edge of entry until the edge of exit. wake is sampled only in the WAIT state; wake asserted in the same cycle a WAIT is accepted is ignored. in_ready=0 throughout WAIT. The cycle after exit, in_ready=1.
- flush: blocks accept that cycle, with no rf write, PSR change or count. Forces WAIT->RUN. Does not cancel an rf_we already registered. Priority: reset_n > flush > wake/accept.
- in_valid with in_ready=0: the input is not consumed. Upstream holds it stable.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles while driving in_valid=1 -> all outputs 0, in_ready=1 after release.
- ADD retire: in_y=0x1234, in_y_valid=1, rdest=5, flags_en=1, sel=5'b11100, in_flags=5'b00100 -> next cycle rf_we=1, waddr=5, wdata=0x1234; psr=5'b00100; retired_count=1.
- CMP mask: psr=5'b10000, CMP with in_y_valid=0, flags=5'b00111, sel=5'b00111 -> rf_we stays 0, psr=5'b10111, count increments.
- ADDC chain: op1 with flags=C, sel=C -> psr_c=1 in the next cycle; op2 accepted back-to-back with flags_en=0 -> psr_c stays 1.
- WAIT: accept WAIT with wake=1 in the same cycle -> waiting=1, in_ready=0. Hold 3 cycles, pulse wake -> waiting=0 next edge, in_ready=1. Count unchanged.
- Flush/wrap: flush concurrent with a valid ADD -> no rf_we, no PSR change. Preload 0xFFFF retires then retire once more -> retired_count=0x0000.

Source files
------------

// File: rtl/alu_wb_stage.sv
// Writeback/retire stage behind the 16-bit ALU: registered RF write port,
// architectural PSR, WAIT stall with wake/flush release, and a retire counter.
module alu_wb_stage #(
  parameter int WIDTH     = 16,
  parameter int RF_ADDR_W = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_y,
  input  logic                 in_y_valid,
  input  logic [4:0]           in_flags,
  input  logic                 in_flags_en,
  input  logic [4:0]           in_flags_sel,
  input  logic [RF_ADDR_W-1:0] in_rdest,
  input  logic                 in_is_wait,
  input  logic                 wake,
  input  logic                 flush,
  output logic                 rf_we,
  output logic [RF_ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]     rf_wdata,
  output logic [4:0]           psr,
  output logic                 psr_c,
  output logic                 waiting,
  output logic [15:0]          retired_count
);

  typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

  state_t state, state_nxt;
  logic   accept;
  logic   wr_nxt;

  assign in_ready = (state == RUN);
  assign accept   = in_valid & in_ready & ~flush;
  assign wr_nxt   = accept & in_y_valid & ~in_is_wait;
  assign waiting  = (state == WAIT);
  assign psr_c    = psr[4];

  // wake only matters once WAIT is entered, so a same-cycle wake is ignored
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:  if (accept && in_is_wait) state_nxt = WAIT;
      WAIT: if (flush || wake)        state_nxt = RUN;
      default:                        state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= RUN;
      rf_we         <= 1'b0;
      rf_waddr      <= '0;
      rf_wdata      <= '0;
      psr           <= '0;
      retired_count <= '0;
    end else begin
      state <= state_nxt;
      rf_we <= wr_nxt;
      if (wr_nxt) begin
        rf_waddr <= in_rdest;
        rf_wdata <= in_y;
      end
      if (accept && in_flags_en)
        psr <= (psr & ~in_flags_sel) | (in_flags & in_flags_sel);
      if (accept && !in_is_wait)
        retired_count <= retired_count + 16'd1;
    end
  end

endmodule
